// File: rtl/prs_pkg.sv
// prs_pkg: definitions shared by the PRS generator and the PRS BER checker.
//   PRS_LEN_DEF / PRS_TAP_DEF : default LFSR length and second feedback tap (1-based)
//   prs_chk_state_t           : checker state machine encoding
//   prs_fb()                  : feedback / prediction bit of an LFSR state
package prs_pkg;

   localparam int PRS_LEN_DEF = 15;
   localparam int PRS_TAP_DEF = 14;
   // Widest LFSR prs_fb() accepts; callers zero-extend their state to this.
   localparam int PRS_MAX     = 64;

   typedef enum logic [1:0] {
      LOAD,
      CHECK,
      LOCKED
   } prs_chk_state_t;

   // Feedback = s[len-1] ^ s[tap-1]. Shifts are used instead of variable
   // bit-selects so any length up to PRS_MAX works without index-width issues.
   function automatic logic prs_fb(input logic [PRS_MAX-1:0] lfsr,
                                   input int                 len,
                                   input int                 tap);
      logic [PRS_MAX-1:0] a;
      logic [PRS_MAX-1:0] b;
      a = lfsr >> (len - 1);
      b = lfsr >> (tap - 1);
      return a[0] ^ b[0];
   endfunction

endpackage

// File: rtl/prs_lfsr.sv
// prs_lfsr: PRS replica register for the BER checker.
//   clk, reset_n : clock, async active-low reset (state clears to 0)
//   i_en         : advance the register this cycle
//   i_load       : 1 = shift in i_sym (load from stream), 0 = shift in feedback
//   i_sym        : received bit used in load mode
//   o_pred       : predicted next bit of the sequence (= feedback)
module prs_lfsr
   import prs_pkg::*;
#(
   parameter int PRS_LEN = PRS_LEN_DEF,
   parameter int PRS_TAP = PRS_TAP_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_en,
   input  logic i_load,
   input  logic i_sym,
   output logic o_pred
);

   logic [PRS_LEN-1:0] lfsr_q, lfsr_d;
   logic [PRS_MAX-1:0] lfsr_ext;

   always_comb begin
      lfsr_ext              = '0;
      lfsr_ext[PRS_LEN-1:0] = lfsr_q;
   end

   assign o_pred = prs_fb(lfsr_ext, PRS_LEN, PRS_TAP);
   assign lfsr_d = {lfsr_q[PRS_LEN-2:0], (i_load ? i_sym : o_pred)};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  lfsr_q <= '0;
      else if (i_en) lfsr_q <= lfsr_d;
   end

endmodule

// File: rtl/prs_ber_checker.sv
// prs_ber_checker: self-synchronising PRS bit-error-rate checker.
//   clk, reset_n : clock, async active-low reset
//   i_clear      : synchronous clear of the running totals (wins over increment)
//   i_win_len    : compared bits per window (0 behaves as 1)
//   i_lock_thr   : max window errors that still count as locked
//   i_vld, i_sym : decoded bit strobe and bit
//   o_locked     : in LOCKED state
//   o_bit_cnt    : saturating bits compared while LOCKED
//   o_err_cnt    : saturating errors counted while LOCKED
//   o_win_err    : error count of the last completed window
//   o_win_vld    : one-cycle pulse when o_win_err updates
module prs_ber_checker
   import prs_pkg::*;
#(
   parameter int PRS_LEN   = PRS_LEN_DEF,
   parameter int PRS_TAP   = PRS_TAP_DEF,
   parameter int CNT_WIDTH = 32,
   parameter int WIN_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_clear,
   input  logic [WIN_WIDTH-1:0] i_win_len,
   input  logic [WIN_WIDTH-1:0] i_lock_thr,
   input  logic                 i_vld,
   input  logic                 i_sym,
   output logic                 o_locked,
   output logic [CNT_WIDTH-1:0] o_bit_cnt,
   output logic [CNT_WIDTH-1:0] o_err_cnt,
   output logic [WIN_WIDTH-1:0] o_win_err,
   output logic                 o_win_vld
);

   localparam int               LCW       = $clog2(PRS_LEN);
   localparam logic [LCW-1:0]   LOAD_LAST = LCW'(PRS_LEN - 1);

   prs_chk_state_t       state_q, state_d;
   logic [LCW-1:0]       load_cnt_q, load_cnt_d;
   logic [WIN_WIDTH-1:0] win_bits_q, win_bits_d;
   logic [WIN_WIDTH-1:0] win_errs_q, win_errs_d;
   logic [WIN_WIDTH-1:0] win_err_q, win_err_d;
   logic                 win_vld_q, win_vld_d;
   logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   logic [WIN_WIDTH-1:0] win_tgt, win_bits_inc, win_errs_inc;
   logic                 pred, err_bit;

   prs_lfsr #(
      .PRS_LEN (PRS_LEN),
      .PRS_TAP (PRS_TAP)
   ) u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (i_vld),
      .i_load  (state_q == LOAD),
      .i_sym   (i_sym),
      .o_pred  (pred)
   );

   assign err_bit = i_sym ^ pred;

   always_comb begin
      state_d      = state_q;
      load_cnt_d   = load_cnt_q;
      win_bits_d   = win_bits_q;
      win_errs_d   = win_errs_q;
      win_err_d    = win_err_q;
      win_vld_d    = 1'b0;
      bit_cnt_d    = bit_cnt_q;
      err_cnt_d    = err_cnt_q;
      win_tgt      = (i_win_len == '0) ? WIN_WIDTH'(1) : i_win_len;
      win_bits_inc = win_bits_q + 1'b1;
      win_errs_inc = win_errs_q + WIN_WIDTH'(err_bit);

      if (i_vld) begin
         case (state_q)
            LOAD: begin
               if (load_cnt_q == LOAD_LAST) begin
                  load_cnt_d = '0;
                  win_bits_d = '0;
                  win_errs_d = '0;
                  state_d    = CHECK;
               end else begin
                  load_cnt_d = load_cnt_q + 1'b1;
               end
            end
            default: begin
               // >= rather than == so a window length lowered mid-window
               // below the bits already counted closes the window at once.
               if (win_bits_inc >= win_tgt) begin
                  win_bits_d = '0;
                  win_errs_d = '0;
                  win_err_d  = win_errs_inc;
                  win_vld_d  = 1'b1;
                  state_d    = (win_errs_inc > i_lock_thr) ? LOAD : LOCKED;
               end else begin
                  win_bits_d = win_bits_inc;
                  win_errs_d = win_errs_inc;
               end
               // Totals use the state at compare time, so the window that
               // drops lock is still counted.
               if (state_q == LOCKED) begin
                  if (bit_cnt_q != '1)            bit_cnt_d = bit_cnt_q + 1'b1;
                  if (err_bit && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
               end
            end
         endcase
      end

      if (i_clear) begin
         bit_cnt_d = '0;
         err_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= LOAD;
         load_cnt_q <= '0;
         win_bits_q <= '0;
         win_errs_q <= '0;
         win_err_q  <= '0;
         win_vld_q  <= 1'b0;
         bit_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         win_bits_q <= win_bits_d;
         win_errs_q <= win_errs_d;
         win_err_q  <= win_err_d;
         win_vld_q  <= win_vld_d;
         bit_cnt_q  <= bit_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign o_locked  = (state_q == LOCKED);
   assign o_bit_cnt = bit_cnt_q;
   assign o_err_cnt = err_cnt_q;
   assign o_win_err = win_err_q;
   assign o_win_vld = win_vld_q;

endmodule

// File: tb/tb_prs_ber_checker.sv
// Directed bench: a 32-bit-total checker and a 4-bit-total checker share one
// stimulus stream produced by a reference PRS generator (x^15 + x^14 + 1).
module tb_prs_ber_checker;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       i_clear;
   logic [9:0] i_win_len, i_lock_thr;
   logic       i_vld, i_sym;

   logic        locked,  win_vld;
   logic [31:0] bit_cnt, err_cnt;
   logic [9:0]  win_err;
   logic        s_locked, s_win_vld;
   logic [3:0]  s_bit_cnt, s_err_cnt;
   logic [9:0]  s_win_err;

   int n_tests = 0;
   int n_fail  = 0;
   logic       wv;
   logic [9:0] we;
   int         exp_err;

   logic [14:0] g = 15'h2ACE;

   always #5 clk = ~clk;

   prs_ber_checker dut (
      .clk(clk), .reset_n(reset_n), .i_clear(i_clear),
      .i_win_len(i_win_len), .i_lock_thr(i_lock_thr),
      .i_vld(i_vld), .i_sym(i_sym),
      .o_locked(locked), .o_bit_cnt(bit_cnt), .o_err_cnt(err_cnt),
      .o_win_err(win_err), .o_win_vld(win_vld)
   );

   prs_ber_checker #(.CNT_WIDTH(4)) dut_s (
      .clk(clk), .reset_n(reset_n), .i_clear(i_clear),
      .i_win_len(i_win_len), .i_lock_thr(i_lock_thr),
      .i_vld(i_vld), .i_sym(i_sym),
      .o_locked(s_locked), .o_bit_cnt(s_bit_cnt), .o_err_cnt(s_err_cnt),
      .o_win_err(s_win_err), .o_win_vld(s_win_vld)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic prs();
      logic b;
      b = g[14] ^ g[13];
      g = {g[13:0], b};
      return b;
   endfunction

   // One valid bit, outputs captured 1 time unit after the accepting edge,
   // then `gap` idle cycles.
   task automatic send(input logic b, input int gap);
      i_vld = 1'b1;
      i_sym = b;
      @(posedge clk); #1;
      wv    = win_vld;
      we    = win_err;
      i_vld = 1'b0;
      i_sym = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic clean(input int n, input int gap);
      for (int i = 0; i < n; i++) send(prs(), gap);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " locked"},  locked,    0);
      chk({tag, " bit"},     bit_cnt,   0);
      chk({tag, " err"},     err_cnt,   0);
      chk({tag, " win_err"}, win_err,   0);
      chk({tag, " win_vld"}, win_vld,   0);
      chk({tag, " s_bit"},   s_bit_cnt, 0);
   endtask

   initial begin
      reset_n = 1'b0; i_clear = 1'b0; i_vld = 1'b0; i_sym = 1'b0;
      i_win_len = 10'd100; i_lock_thr = 10'd5;
      repeat (3) @(posedge clk); #1;
      chk_zero("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Clean sparse stream: lock after 15 + 100 valid bits.
      clean(114, 3);
      chk("A pre-lock", locked, 0);
      clean(1, 3);
      chk("A lock", locked, 1);
      chk("A lock win_vld", wv, 1);
      chk("A lock win_err", we, 0);
      chk("A check bits not totalled", bit_cnt, 0);
      clean(100, 1);
      chk("A win_vld", wv, 1);
      chk("A win_err", we, 0);
      chk("A bit_cnt", bit_cnt, 100);
      chk("A err_cnt", err_cnt, 0);
      chk("A s_bit sat", s_bit_cnt, 15);

      // Injected errors: 1 in 30 over 300-bit windows.
      i_win_len = 10'd300; i_lock_thr = 10'd15;
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 300; i++) send(prs() ^ (i % 30 == 29), 0);
      chk("B win_err", we, 10);
      chk("B locked", locked, 1);
      chk("B err_cnt", err_cnt, 20);
      chk("B bit_cnt", bit_cnt, 700);
      chk("B s_err sat", s_err_cnt, 15);

      // Clear colliding with an erroneous bit.
      i_win_len = 10'd10; i_lock_thr = 10'd5;
      clean(4, 0);
      i_clear = 1'b1;
      send(~prs(), 0);
      i_clear = 1'b0;
      chk("C bit_cnt cleared", bit_cnt, 0);
      chk("C err_cnt cleared", err_cnt, 0);
      clean(5, 0);
      chk("C win_err keeps err", we, 1);
      chk("C locked", locked, 1);
      chk("C bit_cnt", bit_cnt, 5);

      // Loss of lock: stream switches to constant 0 inside a window.
      i_win_len = 10'd20;
      exp_err = 0;
      clean(3, 0);
      for (int i = 0; i < 17; i++) begin
         exp_err += int'(prs());
         send(1'b0, 0);
      end
      chk("D win_vld", wv, 1);
      chk("D win_err", we, exp_err);
      chk("D locked", locked, (exp_err > 5) ? 0 : 1);
      chk("D bit_cnt", bit_cnt, 25);
      chk("D err_cnt", err_cnt, exp_err);

      // Relock from LOAD after 15 + 20 bits.
      clean(34, 0);
      chk("D relock early", locked, 0);
      clean(1, 0);
      chk("D relock", locked, 1);
      chk("D bit_cnt held", bit_cnt, 25);

      // Reset mid-window.
      clean(7, 0);
      reset_n = 1'b0;
      #2;
      chk_zero("E reset");
      reset_n = 1'b1;
      @(posedge clk); #1;
      clean(34, 0);
      chk("E relock early", locked, 0);
      clean(1, 0);
      chk("E relock", locked, 1);

      // Window length zero behaves as one bit per window.
      i_win_len = 10'd0;
      clean(1, 0);
      chk("F win_vld 0", wv, 1);
      chk("F win_err 0", we, 0);
      send(~prs(), 0);
      chk("F win_vld 1", wv, 1);
      chk("F win_err 1", we, 1);
      clean(1, 0);
      chk("F win_vld 2", wv, 1);
      chk("F win_err 2", we, 0);
      chk("F bit_cnt", bit_cnt, 3);
      chk("F err_cnt", err_cnt, 1);
      chk("F locked", locked, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prs_ber_checker.md
# prs_ber_checker

Bit-error-rate checker placed directly downstream of `fano_decoder`. It consumes the decoded bit stream (`o_vld`/`o_dec_sym`) and self-synchronises a local pseudo-random sequence (PRS) replica to it. Once locked, it counts compared bits and bit errors over fixed windows and as running totals, so link quality can be measured in simulation and on hardware without an external analyser. The PRS polynomial matches the one used by `prs_gen`.

## Interface

Parameters:

- `PRS_LEN` (default 15): LFSR length. Feedback is `s[PRS_LEN-1] ^ s[PRS_TAP-1]`.
- `PRS_TAP` (default 14): second feedback tap, 1-based.
- `CNT_WIDTH` (default 32): width of the running total counters.
- `WIN_WIDTH` (default 10): width of the window length, threshold and window error count.

Ports:

- `clk` in, 1: single clock for the whole block.
- `reset_n` in, 1: reset, asynchronous and active-low.
- `i_clear` in, 1: synchronous clear of the running totals.
- `i_win_len` in, WIN_WIDTH: compared bits per window. A value of 0 is treated as 1.
- `i_lock_thr` in, WIN_WIDTH: maximum window errors that still count as locked.
- `i_vld` in, 1: decoded bit strobe. No backpressure is applied.
- `i_sym` in, 1: decoded bit.
- `o_locked` out, 1: checker is in the LOCKED state.
- `o_bit_cnt` out, CNT_WIDTH: total bits compared while LOCKED. Saturates.
- `o_err_cnt` out, CNT_WIDTH: total errors counted while LOCKED. Saturates.
- `o_win_err` out, WIN_WIDTH: error count of the last completed window.
- `o_win_vld` out, 1: one-cycle pulse when `o_win_err` updates.

## Operation

- Bits are processed only on cycles with `i_vld=1`. Cycles with `i_vld=0` leave all state unchanged.
- Prediction is `p = lfsr[PRS_LEN-1] ^ lfsr[PRS_TAP-1]`. Error is `e = i_sym ^ p`.
- State machine: LOAD, CHECK, LOCKED.
- LOAD:
  - Shift `lfsr <= {lfsr[PRS_LEN-2:0], i_sym}`, i.e. load from received bits.
  - Count loaded bits. After `PRS_LEN` bits, go to CHECK with the window counters zeroed.
- CHECK and LOCKED:
  - Shift `lfsr <= {lfsr[PRS_LEN-2:0], p}` (free-run; received bits are never fed back).
  - Increment the window bit counter. Add `e` to the window error counter.
- Window end, on the bit that makes the window bit count equal `max(i_win_len,1)`:
  - Latch `o_win_err` with the window total including this bit, and pulse `o_win_vld`.
  - Clear both window counters.
  - From CHECK: go to LOCKED if errors ≤ `i_lock_thr`, otherwise go to LOAD.
  - From LOCKED: go to LOAD if errors > `i_lock_thr`, otherwise stay in LOCKED.
- Totals:
  - In LOCKED, every compared bit increments `o_bit_cnt` and adds `e` to `o_err_cnt`, including the window that drops lock.
  - CHECK bits are never added to the totals.
  - Both totals saturate at all-ones independently.
- `i_clear`: zeroes both totals. It has priority over a same-cycle increment; that cycle's bit is not added. It does not affect state, LFSR, window counters or `o_win_err`.
- An all-zero LFSR after LOAD is legal. It yields a high error count and a lock failure, which returns the checker to LOAD.
- `i_win_len` and `i_lock_thr` are sampled at each use. Changing them mid-window takes effect at the next comparison.

## Timing

- All outputs are registered. The effect of a bit accepted in cycle N is visible in cycle N+1.
- Reset values:
  - State LOAD, LFSR 0, all counters 0.
  - `o_locked=0`, `o_bit_cnt=0`, `o_err_cnt=0`, `o_win_err=0`, `o_win_vld=0`.
- `o_win_vld` is high for exactly one cycle. `o_locked` changes in the same cycle as that pulse.
- Minimum time to lock: `PRS_LEN + max(i_win_len,1)` valid bits.
- Asserting `reset_n=0` mid-window returns everything to reset values immediately. Partial window results are discarded.
- Back-to-back `i_vld` (every cycle) is supported at full rate.

## Structure

- Package `prs_pkg`:
  - `localparam`s `PRS_LEN_DEF=15` and `PRS_TAP_DEF=14`.
  - State enum `prs_chk_state_t {LOAD, CHECK, LOCKED}`.
  - Function `prs_fb(lfsr)` returning the feedback bit. This package is shared with `prs_gen`.
- Sub-module `prs_lfsr`: LFSR register with `i_load` mode (shift in external bit) and run mode (shift in feedback). It outputs the prediction bit `p`.
- The top level holds the state machine, the window counters and the saturating totals.

## Test plan

- **Clean stream.** Feed `prs_gen` output with `i_vld` every 64 cycles, `i_win_len=100`, `i_lock_thr=5`.
  - Required: `o_locked=1` after 115 valid bits.
  - Required: every `o_win_err=0`.
  - Required: `o_bit_cnt` increments by 100 per window and `o_err_cnt` stays 0.
- **Injected errors.** Clean stream, then invert 1 bit in every 30 after lock (`i_win_len=300`).
  - Required: `o_win_err=10` per window and `o_locked` stays 1.
  - Required: `o_err_cnt` increases by exactly 10 per window.
- **Loss of lock.** After lock, replace the stream with constant 0.
  - Required: the window containing the switch reports > 5 errors and `o_locked` drops with that `o_win_vld`.
  - Required: relock is attempted from LOAD.
- **Clear collision.** Assert `i_clear` on the same cycle as an erroneous `i_vld` bit while LOCKED.
  - Required: next cycle `o_bit_cnt=0`, `o_err_cnt=0`, and the window count still includes that error.
- **Saturation and reset.** Use `CNT_WIDTH=4` with a clean locked stream of 20 bits.
  - Required: `o_bit_cnt` holds 15.
  - Then pulse `reset_n` low mid-window. Required: all outputs 0 and a fresh lock after `PRS_LEN+i_win_len` bits.
- **Window length zero.** `i_win_len=0`.
  - Required: `o_win_vld` pulses after every valid bit in CHECK/LOCKED, with `o_win_err` ∈ {0,1}.
